// File: rtl/fpu_ss_wb_arbiter.sv
// rtl/fpu_ss_wb_arbiter.sv - FP regfile writeback arbiter: FPU vs. load results, load FIFO, busy scoreboard
module fpu_ss_wb_arbiter #(
    parameter int unsigned MemFifoDepth = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fpu_valid_i,
    output logic        fpu_ready_o,
    input  logic [4:0]  fpu_rd_i,
    input  logic [31:0] fpu_data_i,
    input  logic        mem_valid_i,
    input  logic [4:0]  mem_rd_i,
    input  logic [31:0] mem_data_i,
    output logic        mem_almost_full_o,
    input  logic        set_valid_i,
    input  logic [4:0]  set_rd_i,
    output logic [31:0] busy_o,
    output logic [4:0]  waddr_o,
    output logic [31:0] wdata_o,
    output logic        we_o
);

    localparam int unsigned PtrW = $clog2(MemFifoDepth);
    localparam int unsigned CntW = PtrW + 1;

    logic [4:0]      fifo_rd_q   [MemFifoDepth];
    logic [31:0]     fifo_data_q [MemFifoDepth];
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0] count_q;

    logic        fifo_full, fifo_empty;
    logic        pop, push, bypass, win;
    logic [4:0]  win_rd;
    logic [31:0] win_data;
    logic [31:0] busy_next;

    assign fifo_full         = (count_q == CntW'(MemFifoDepth));
    assign fifo_empty        = (count_q == '0);
    assign fpu_ready_o       = !rst_i && !fifo_full;
    assign mem_almost_full_o = (count_q >= CntW'(MemFifoDepth - 1));
    assign push              = mem_valid_i && !bypass;

    // A full FIFO outranks the FPU so a load arriving this cycle always has a slot.
    always_comb begin
        pop      = 1'b0;
        bypass   = 1'b0;
        win      = 1'b0;
        win_rd   = '0;
        win_data = '0;
        if (fifo_full) begin
            pop      = 1'b1;
            win      = 1'b1;
            win_rd   = fifo_rd_q[rptr_q];
            win_data = fifo_data_q[rptr_q];
        end else if (fpu_valid_i) begin
            win      = 1'b1;
            win_rd   = fpu_rd_i;
            win_data = fpu_data_i;
        end else if (!fifo_empty) begin
            pop      = 1'b1;
            win      = 1'b1;
            win_rd   = fifo_rd_q[rptr_q];
            win_data = fifo_data_q[rptr_q];
        end else if (mem_valid_i) begin
            bypass   = 1'b1;
            win      = 1'b1;
            win_rd   = mem_rd_i;
            win_data = mem_data_i;
        end
    end

    // Clear follows the regfile write; a same-cycle set is applied last so it wins.
    always_comb begin
        busy_next = busy_o;
        if (we_o) begin
            busy_next[waddr_o] = 1'b0;
        end
        if (set_valid_i) begin
            busy_next[set_rd_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_rd_q[wptr_q]   <= mem_rd_i;
            fifo_data_q[wptr_q] <= mem_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            we_o    <= 1'b0;
            waddr_o <= '0;
            wdata_o <= '0;
            busy_o  <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            count_q <= count_q + CntW'(push) - CntW'(pop);
            we_o    <= win;
            if (win) begin
                waddr_o <= win_rd;
                wdata_o <= win_data;
            end
            busy_o <= busy_next;
        end
    end

    a_no_load_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
        !(mem_valid_i && fifo_full && !pop));

    a_fpu_valid_stable : assert property (@(posedge clk_i) disable iff (rst_i)
        (fpu_valid_i && !fpu_ready_o) |=> fpu_valid_i);

endmodule
